// File: rtl/arb_pkg.sv
// arb_pkg: shared types and constants for the 8-way round-robin arbiter
package arb_pkg;
    typedef enum logic {IDLE, OWN} state_t;
    typedef logic [2:0] idx_t;
    localparam int NREQ = 8;
    localparam int HOLD_MAX_DEF = 16;
endpackage

// File: rtl/mux8_1.sv
// mux8_1: 1-bit 8:1 multiplexer
module mux8_1 (
    input  logic [7:0] in,
    input  logic [2:0] sel,
    output logic       out
);
    assign out = in[sel];
endmodule

// File: rtl/rr_pick8.sv
// rr_pick8: combinational round-robin search, first set req bit from ptr+1 upward mod 8
module rr_pick8
    import arb_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  idx_t            ptr,
    output idx_t            idx,
    output logic            any
);
    // scan from farthest (ptr itself) to nearest so the nearest set bit wins
    always_comb begin
        idx = ptr;
        for (int i = NREQ; i >= 1; i--)
            if (req[ptr + 3'(i)]) idx = ptr + 3'(i);
    end
    assign any = |req;
endmodule

// File: rtl/rr_arb8.sv
// rr_arb8: 8-way round-robin arbiter with registered one-hot grant; ARB_TIMEOUT_EN adds hold-time limit
module rr_arb8
    import arb_pkg::*;
#(
    parameter int HOLD_MAX = HOLD_MAX_DEF
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] data,
    output logic [NREQ-1:0] gnt,
    output idx_t            sel,
    output logic            gnt_valid,
    output logic            out
);
    state_t          state;
    idx_t            ptr;
    idx_t            pick_ptr;
    idx_t            pick_idx;
    logic [NREQ-1:0] pick_req;
    logic            pick_any;
    logic            rel;
    logic            force_rel;
    logic            mux_out;

    // while owning, search past the owner and exclude it so a handover never re-picks it
    assign pick_ptr = (state == OWN) ? sel : ptr;
    assign pick_req = (state == OWN) ? (req & ~gnt) : req;
    assign rel      = (state == OWN) && (!req[sel] || force_rel);

    rr_pick8 u_pick (
        .req (pick_req),
        .ptr (pick_ptr),
        .idx (pick_idx),
        .any (pick_any)
    );

`ifdef ARB_TIMEOUT_EN
    logic [7:0] cnt;
    assign force_rel = (cnt == 8'(HOLD_MAX - 1)) && pick_any;
    // hold counter: cleared on each new grant, saturates when the owner is alone
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            cnt <= 8'd0;
        else if (state == IDLE || rel)
            cnt <= 8'd0;
        else if (cnt != 8'(HOLD_MAX - 1))
            cnt <= cnt + 8'd1;
    end
`else
    assign force_rel = 1'b0;
`endif

    // arbitration state: grant from IDLE, hold while owner requests, hand over or idle on release
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            ptr       <= 3'd7;
            sel       <= 3'd0;
            gnt       <= '0;
            gnt_valid <= 1'b0;
        end else if (state == IDLE) begin
            if (pick_any) begin
                state     <= OWN;
                sel       <= pick_idx;
                gnt       <= 8'b1 << pick_idx;
                gnt_valid <= 1'b1;
            end
        end else if (rel) begin
            ptr <= sel;
            if (pick_any) begin
                sel <= pick_idx;
                gnt <= 8'b1 << pick_idx;
            end else begin
                state     <= IDLE;
                gnt       <= '0;
                gnt_valid <= 1'b0;
            end
        end
    end

    mux8_1 u_mux (
        .in  (data),
        .sel (sel),
        .out (mux_out)
    );

    assign out = gnt_valid & mux_out;
endmodule

// File: tb/tb_rr_arb8.sv
// tb_rr_arb8: directed self-checking bench for rr_arb8 (timeout steps active when ARB_TIMEOUT_EN is defined)
module tb_rr_arb8;
    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] req;
    logic [7:0] data;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       gnt_valid;
    logic       out;
    int         checks = 0;
    int         failures = 0;

    rr_arb8 #(.HOLD_MAX(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req),
        .data      (data),
        .gnt       (gnt),
        .sel       (sel),
        .gnt_valid (gnt_valid),
        .out       (out)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_own(input string tag, input int o);
        chk({tag, "_gnt"}, 32'(gnt), 32'(8'b1 << o));
        chk({tag, "_sel"}, 32'(sel), 32'(o));
        chk({tag, "_gv"}, 32'(gnt_valid), 32'd1);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_gnt"}, 32'(gnt), 32'h0);
        chk({tag, "_gv"}, 32'(gnt_valid), 32'd0);
        chk({tag, "_out"}, 32'(out), 32'd0);
    endtask

    initial begin
        reset_n = 1'b0;
        req     = 8'h00;
        data    = 8'hFF;
        #1;
        chk_idle("reset");
        chk("reset_sel", 32'(sel), 32'd0);
        step;
        #2 reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step;
            chk_idle("idle5");
        end
        data = 8'h00;
        req  = 8'hFF;
        step;
        for (int o = 0; o < 8; o++) begin
            chk_own("rr_a", o);
            step;
            chk_own("rr_b", o);
            step;
            chk_own("rr_c", o);
            req = 8'hFF & ~(8'b1 << o);
            step;
            req = 8'hFF;
        end
        chk_own("rr_wrap", 0);
        req = 8'h00;
        step;
        chk_idle("rel_idle");
        req = 8'h04;
        step;
        chk_own("own2", 2);
        req  = 8'h84;
        data = 8'h04;
        step;
        chk_own("own2_hold", 2);
        chk("own2_out", 32'(out), 32'd1);
        req = 8'h80;
        step;
        chk_own("hand7", 7);
        chk("hand7_out", 32'(out), 32'd0);
        data = 8'h80;
        #1;
        chk("hand7_out_d", 32'(out), 32'd1);
        req = 8'h00;
        step;
        req = 8'h20;
        step;
        chk_own("own5", 5);
        req = 8'h00;
        step;
        chk_idle("idle_p5");
        chk("idle_sel_keep", 32'(sel), 32'd5);
        req = 8'h21;
        step;
        chk_own("wrap0", 0);
        req = 8'h00;
        step;
        req = 8'h03;
        step;
        chk_own("ptr0_low", 1);
        data = 8'h02;
        #1;
        chk("own1_out", 32'(out), 32'd1);
        #1 reset_n = 1'b0;
        #1;
        chk_idle("async_rst");
        chk("async_rst_sel", 32'(sel), 32'd0);
        #2;
        reset_n = 1'b1;
        req     = 8'h10;
        step;
        chk_own("post_rst", 4);
`ifdef ARB_TIMEOUT_EN
        req = 8'h00;
        reset_n = 1'b0;
        #2 reset_n = 1'b1;
        req = 8'h03;
        step;
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 4; c++) begin
                chk_own("to_a", 0);
                step;
            end
            for (int c = 0; c < 4; c++) begin
                chk_own("to_b", 1);
                step;
            end
        end
        req = 8'h01;
        step;
        for (int c = 0; c < 10; c++) begin
            chk_own("to_sat", 0);
            step;
        end
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
